// File: rtl/ps2_ascii_pkg.sv
// Shared scan-code constants, parser state and keymap entry types for the
// PS/2 Set-2 to ASCII translator.
package ps2_ascii_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_state_e;

  typedef enum logic [1:0] {KC_NONE, KC_LETTER, KC_SYMBOL, KC_PLAIN} key_class_e;

  typedef struct packed {
    key_class_e  cls;
    logic [7:0]  base;
    logic [7:0]  shifted;
  } key_entry_t;

  // Keyboard self-test / ack / echo / resend / error bytes are not keys.
  function automatic logic is_device_response(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational Set-2 make-code to ASCII lookup. Letters follow shift XOR caps,
// digits/symbols follow shift only, whitespace/control keys are never shifted.
module ps2_keymap
  import ps2_ascii_pkg::*;
(
  input  logic [7:0] scan_byte,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic       known
);

  key_entry_t entry;

  always_comb begin
    entry = '{KC_NONE, 8'h00, 8'h00};
    case (scan_byte)
      8'h1C: entry = '{KC_LETTER, 8'h61, 8'h00};
      8'h32: entry = '{KC_LETTER, 8'h62, 8'h00};
      8'h21: entry = '{KC_LETTER, 8'h63, 8'h00};
      8'h23: entry = '{KC_LETTER, 8'h64, 8'h00};
      8'h24: entry = '{KC_LETTER, 8'h65, 8'h00};
      8'h2B: entry = '{KC_LETTER, 8'h66, 8'h00};
      8'h34: entry = '{KC_LETTER, 8'h67, 8'h00};
      8'h33: entry = '{KC_LETTER, 8'h68, 8'h00};
      8'h43: entry = '{KC_LETTER, 8'h69, 8'h00};
      8'h3B: entry = '{KC_LETTER, 8'h6A, 8'h00};
      8'h42: entry = '{KC_LETTER, 8'h6B, 8'h00};
      8'h4B: entry = '{KC_LETTER, 8'h6C, 8'h00};
      8'h3A: entry = '{KC_LETTER, 8'h6D, 8'h00};
      8'h31: entry = '{KC_LETTER, 8'h6E, 8'h00};
      8'h44: entry = '{KC_LETTER, 8'h6F, 8'h00};
      8'h4D: entry = '{KC_LETTER, 8'h70, 8'h00};
      8'h15: entry = '{KC_LETTER, 8'h71, 8'h00};
      8'h2D: entry = '{KC_LETTER, 8'h72, 8'h00};
      8'h1B: entry = '{KC_LETTER, 8'h73, 8'h00};
      8'h2C: entry = '{KC_LETTER, 8'h74, 8'h00};
      8'h3C: entry = '{KC_LETTER, 8'h75, 8'h00};
      8'h2A: entry = '{KC_LETTER, 8'h76, 8'h00};
      8'h1D: entry = '{KC_LETTER, 8'h77, 8'h00};
      8'h22: entry = '{KC_LETTER, 8'h78, 8'h00};
      8'h35: entry = '{KC_LETTER, 8'h79, 8'h00};
      8'h1A: entry = '{KC_LETTER, 8'h7A, 8'h00};
      8'h45: entry = '{KC_SYMBOL, 8'h30, 8'h29};
      8'h16: entry = '{KC_SYMBOL, 8'h31, 8'h21};
      8'h1E: entry = '{KC_SYMBOL, 8'h32, 8'h40};
      8'h26: entry = '{KC_SYMBOL, 8'h33, 8'h23};
      8'h25: entry = '{KC_SYMBOL, 8'h34, 8'h24};
      8'h2E: entry = '{KC_SYMBOL, 8'h35, 8'h25};
      8'h36: entry = '{KC_SYMBOL, 8'h36, 8'h5E};
      8'h3D: entry = '{KC_SYMBOL, 8'h37, 8'h26};
      8'h3E: entry = '{KC_SYMBOL, 8'h38, 8'h2A};
      8'h46: entry = '{KC_SYMBOL, 8'h39, 8'h28};
      8'h0E: entry = '{KC_SYMBOL, 8'h60, 8'h7E};
      8'h4E: entry = '{KC_SYMBOL, 8'h2D, 8'h5F};
      8'h55: entry = '{KC_SYMBOL, 8'h3D, 8'h2B};
      8'h54: entry = '{KC_SYMBOL, 8'h5B, 8'h7B};
      8'h5B: entry = '{KC_SYMBOL, 8'h5D, 8'h7D};
      8'h5D: entry = '{KC_SYMBOL, 8'h5C, 8'h7C};
      8'h4C: entry = '{KC_SYMBOL, 8'h3B, 8'h3A};
      8'h52: entry = '{KC_SYMBOL, 8'h27, 8'h22};
      8'h41: entry = '{KC_SYMBOL, 8'h2C, 8'h3C};
      8'h49: entry = '{KC_SYMBOL, 8'h2E, 8'h3E};
      8'h4A: entry = '{KC_SYMBOL, 8'h2F, 8'h3F};
      8'h29: entry = '{KC_PLAIN,  8'h20, 8'h00};
      8'h5A: entry = '{KC_PLAIN,  8'h0D, 8'h00};
      8'h66: entry = '{KC_PLAIN,  8'h08, 8'h00};
      8'h0D: entry = '{KC_PLAIN,  8'h09, 8'h00};
      default: entry = '{KC_NONE, 8'h00, 8'h00};
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    known = 1'b0;
    case (entry.cls)
      KC_LETTER: begin
        ascii = (shift ^ caps) ? (entry.base - 8'h20) : entry.base;
        known = 1'b1;
      end
      KC_SYMBOL: begin
        ascii = shift ? entry.shifted : entry.base;
        known = 1'b1;
      end
      KC_PLAIN: begin
        ascii = entry.base;
        known = 1'b1;
      end
      default: begin
        ascii = 8'h00;
        known = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ps2_ascii_translator.sv
// PS/2 Set-2 scan-code to ASCII translator: E0/F0 prefix parser, Shift tracking,
// output FIFO with ready/valid. Caps Lock support is built when PS2_CAPSLOCK_EN is defined.
module ps2_ascii_translator
  import ps2_ascii_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] UNKNOWN_CHAR = 8'h2A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_byte,
  input  logic       ascii_ready,
  output logic       ascii_valid,
  output logic [7:0] ascii_data,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_active,
  output logic       caps_active
);

  localparam int AW = $clog2(FIFO_DEPTH);

  parse_state_e state, state_next;
  logic         lshift, rshift, lshift_next, rshift_next;
  logic         produce;
  logic [7:0]   produce_char;
  logic [7:0]   km_ascii;
  logic         km_known;

  logic [7:0]   mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         push, pop;

`ifdef PS2_CAPSLOCK_EN
  logic caps, caps_held, caps_next, caps_held_next;
  assign caps_active = caps;
`else
  assign caps_active = 1'b0;
`endif

  assign shift_active = lshift | rshift;

  ps2_keymap u_keymap (
    .scan_byte (scan_byte),
    .shift     (shift_active),
    .caps      (caps_active),
    .ascii     (km_ascii),
    .known     (km_known)
  );

  // Parser next-state, modifier updates and character production
  always_comb begin
    state_next   = state;
    lshift_next  = lshift;
    rshift_next  = rshift;
    produce      = 1'b0;
    produce_char = 8'h00;
`ifdef PS2_CAPSLOCK_EN
    caps_next      = caps;
    caps_held_next = caps_held;
`endif
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_byte == SC_EXT) begin
            state_next = EXT;
          end else if (scan_byte == SC_BRK) begin
            state_next = BRK;
          end else begin
            case (scan_byte)
              SC_LSHIFT: lshift_next = 1'b1;
              SC_RSHIFT: rshift_next = 1'b1;
              SC_CAPS: begin
`ifdef PS2_CAPSLOCK_EN
                if (!caps_held) begin
                  caps_next      = ~caps;
                  caps_held_next = 1'b1;
                end else begin
                  caps_next      = caps;
                end
`endif
              end
              SC_CTRL, SC_ALT: begin
              end
              default: begin
                if (is_device_response(scan_byte)) begin
                  produce = 1'b0;
                end else begin
                  produce      = 1'b1;
                  produce_char = km_known ? km_ascii : UNKNOWN_CHAR;
                end
              end
            endcase
          end
        end
        EXT: begin
          if (scan_byte == SC_BRK) begin
            state_next = EXT_BRK;
          end else begin
            state_next = IDLE;
            if (scan_byte == 8'h5A) begin
              produce      = 1'b1;
              produce_char = 8'h0D;
            end else if (scan_byte == 8'h4A) begin
              produce      = 1'b1;
              produce_char = 8'h2F;
            end else begin
              produce = 1'b0;
            end
          end
        end
        BRK: begin
          state_next = IDLE;
          case (scan_byte)
            SC_LSHIFT: lshift_next = 1'b0;
            SC_RSHIFT: rshift_next = 1'b0;
`ifdef PS2_CAPSLOCK_EN
            SC_CAPS:   caps_held_next = 1'b0;
`endif
            default: begin
            end
          endcase
        end
        EXT_BRK: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  assign ascii_valid = (wr_ptr != rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ascii_data  = ascii_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign pop         = ascii_valid & ascii_ready;
  assign push        = produce & (~fifo_full | pop);

  // Parser state, modifiers, FIFO pointers and overflow pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
`ifdef PS2_CAPSLOCK_EN
      caps      <= 1'b0;
      caps_held <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      lshift   <= lshift_next;
      rshift   <= rshift_next;
      overflow <= produce & fifo_full & ~pop;
`ifdef PS2_CAPSLOCK_EN
      caps      <= caps_next;
      caps_held <= caps_held_next;
`endif
      if (push) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= produce_char;
    end
  end

endmodule
